// File: rtl/counter_pkg.sv
// Shared definitions for the counter datapath: repeat FSM encoding and default timing.
package counter_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 1000;
  localparam int DEF_REPEAT_PERIOD   = 250;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, debounce counter, registered stable level and
// a one-cycle press indication (combinational, valid in the cycle after stable rises).
module btn_debounce
  import counter_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw level in; a new level must persist DEBOUNCE_CYCLES compares to be accepted.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_out == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Channel state registers; reset discards all history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_q & ~prev_q;

endmodule

// File: rtl/counter_btn_conditioner.sv
// Button input stage: two debounced channels, per-channel hold-to-repeat FSMs,
// up/down arbitration and registered inc/dec strobes for the counter core.
module counter_btn_conditioner
  import counter_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_up,
  input  logic btn_down,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic up_held,
  output logic down_held
);

  localparam int NCH = 2;  // channel 0 = up, channel 1 = down
  localparam int RW  = $clog2(REPEAT_DELAY + 1);

  logic [NCH-1:0]          btn_raw, st, press, fire;
  logic                    both;
  rpt_state_e [NCH-1:0]    state_q, state_d;
  logic [NCH-1:0][RW-1:0]  rcnt_q, rcnt_d;
  logic                    inc_q, inc_d, dec_q, dec_d;

  assign btn_raw = {btn_down, btn_up};

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_raw[g]),
      .stable_o(st[g]),
      .press_o (press[g])
    );
  end

  // Repeat FSMs and strobe selection. Both held parks both channels in DELAY with a
  // cleared count, so releasing one restarts the other's full repeat delay.
  // The count fires on the edge it would reach REPEAT_DELAY and reloads so the
  // next fire is REPEAT_PERIOD cycles later; it therefore never holds REPEAT_DELAY.
  always_comb begin
    both = &st;
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      rcnt_d[ch]  = rcnt_q[ch];
      fire[ch]    = 1'b0;
      if (!st[ch]) begin
        state_d[ch] = RPT_IDLE;
        rcnt_d[ch]  = '0;
      end else if (both || press[ch]) begin
        state_d[ch] = RPT_DELAY;
        rcnt_d[ch]  = '0;
      end else if (state_q[ch] != RPT_IDLE) begin
        if (rcnt_q[ch] == RW'(REPEAT_DELAY - 1)) begin
          fire[ch]    = 1'b1;
          state_d[ch] = RPT_REPEAT;
          rcnt_d[ch]  = RW'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rcnt_d[ch] = rcnt_q[ch] + RW'(1);
        end
      end
    end
    inc_d = ena & ((press[0] & ~both) | fire[0]);
    dec_d = ena & ((press[1] & ~both) | fire[1]);
  end

  // FSM, repeat counters and output strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        state_q[ch] <= RPT_IDLE;
        rcnt_q[ch]  <= '0;
      end
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign up_held   = st[0];
  assign down_held = st[1];

endmodule
